reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Parametrised multi-channel power-up reset sequencer: next generation of the team's fixed one-second startup delay.
- Holds CHANNELS active-high reset outputs asserted until a clock-stable input (e.g. MMCM/CMAC locked) has been high for LOCK_FILTER consecutive cycles.
- After that, releases the channels one at a time: channel 0 after FIRST_DELAY cycles, each later channel STAGE_DELAY cycles after the previous one.
- Any loss of lock or a software restart re-asserts every channel and restarts the sequence.
- Placement: at the top of each clock domain, ahead of CMAC, transceivers and downstream user logic.

Parameters:
- CHANNELS, 4, number of reset outputs (1..16).
- LOCK_FILTER, 1000, consecutive cycles locked_in must be high before sequencing starts (>=1).
- FIRST_DELAY, 250000000, cycles from lock qualified to channel 0 release (>=1; 1 s at 250 MHz).
- STAGE_DELAY, 25000000, cycles between successive channel releases (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- locked_in  input  1  clock-stable indication; may be asynchronous to clk, so it is double-flop synchronised internally.
- restart  input  1  single-cycle pulse; forces a full re-sequence.
- reset_out  output  CHANNELS  active-high reset per channel; bit k releases k-th.
- done  output  1  high once every channel is released.
- loss_count  output  16  saturating count of aborts caused by lock loss.

Behaviour:
- All outputs registered.
- On reset:
  - state = WAIT_LOCK, reset_out = all ones, done = 0, loss_count = 0.
  - Internal stage index = 0, timer = 0, lock filter counter = 0.
- Internal timer is 32 bits; all delay parameters must fit in 32 bits.
- "lk" below = locked_in after the 2-flop synchroniser. lk lags locked_in by 2 cycles, and all cycle counts below are measured from lk.
- Priority, highest first: reset; then abort (lk==0 or restart==1) in any state other than WAIT_LOCK; then normal transitions.
- Abort action:
  - reset_out = all ones, done = 0, filter counter = 0, state = WAIT_LOCK.
  - loss_count increments (saturates at 0xFFFF) only when the abort cause includes lk==0.
- restart while in WAIT_LOCK: only clears the filter counter.
- WAIT_LOCK:
  - While lk==1, filter counter increments; when lk==0, it clears.
  - On the edge where lk==1 and counter==LOCK_FILTER-1: load timer = FIRST_DELAY-1, go to DELAY.
  - That edge is the LOCK_FILTER-th consecutive edge sampling lk high.
- DELAY:
  - Timer decrements each cycle.
  - On the edge where timer==0: clear reset_out[0], set stage = 1.
  - If CHANNELS==1: go to DONE and set done = 1 on that same edge.
  - Otherwise: load timer = STAGE_DELAY-1, go to RELEASE.
- RELEASE:
  - Timer decrements each cycle.
  - On the edge where timer==0: clear reset_out[stage].
  - If stage==CHANNELS-1: go to DONE and set done = 1 on that same edge.
  - Otherwise: stage++, reload timer = STAGE_DELAY-1.
- DONE: holds until abort or reset. reset_out = 0, done = 1.
- Resulting timing, with E1 = first edge sampling lk high after WAIT_LOCK entry:
  - reset_out[k] falls at edge E(LOCK_FILTER + FIRST_DELAY + k*STAGE_DELAY).
  - done rises on the same edge as reset_out[CHANNELS-1] falls.
- Released channels never re-assert except via abort or reset.
- Abort mid-sequence re-asserts already-released channels on the next edge. The sequence then restarts from lock filtering with full delays, with no partial credit.
- A lk glitch of 1 cycle during WAIT_LOCK fully restarts the filter count.
- Simultaneous lk==0 and restart: a single abort; loss_count increments once.
- reset asserted mid-sequence: returns to the reset values on the next edge; loss_count is cleared.

Test Plan (CHANNELS=3, LOCK_FILTER=4, FIRST_DELAY=10, STAGE_DELAY=5 unless stated):
- Clean power-up: reset 2 cycles, then locked_in held high.
  - reset_out = 3'b111 until lk edge 14, then 3'b110; 3'b100 at edge 19; 3'b000 and done=1 at edge 24.
  - loss_count = 0 throughout.
- Lock filter: lk high 3 cycles, low 1, then high.
  - Filter restarts; reset_out[0] falls 14 edges after the second rise.
  - reset_out stays 3'b111 before that.
- Lock loss mid-sequence: lk drops at edge 20 (reset_out = 3'b100).
  - Next edge: reset_out = 3'b111, done = 0, loss_count = 1.
  - Re-lock then gives the full 14/19/24 timing again.
- restart pulse in DONE:
  - reset_out = 3'b111 and done = 0 on the next edge; loss_count unchanged.
  - Re-sequence completes 24 edges later with lk still high.
- Saturation: force 65537 lock-loss aborts (shortened run via repeated lk toggles) -> loss_count = 16'hFFFF; reset -> 0.
- Single channel with minimum delays (CHANNELS=1, LOCK_FILTER=1, FIRST_DELAY=1): reset_out[0] and done change together at lk edge 2.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Multi-channel power-up reset sequencer. Holds every reset output asserted
//   until the clock-stable indication has been continuously high for
//   LOCK_FILTER cycles. It then releases channel 0 after FIRST_DELAY cycles,
//   and each later channel STAGE_DELAY cycles after the previous one. Losing
//   lock or a restart pulse re-asserts all channels and starts over.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       synchronous, active-high reset
//   locked_in   clock-stable indication (may be asynchronous; synchronised here)
//   restart     single-cycle pulse forcing a full re-sequence
//   reset_out   active-high reset per channel; bit k is released k-th
//   done        high once every channel has been released
//   loss_count  saturating count of aborts caused by loss of lock
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int LOCK_FILTER = 1000,
  parameter int FIRST_DELAY = 250000000,
  parameter int STAGE_DELAY = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                locked_in,
  input  logic                restart,
  output logic [CHANNELS-1:0] reset_out,
  output logic                done,
  output logic [15:0]         loss_count
);

  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [31:0]       LF_M1    = 32'(LOCK_FILTER - 1);
  localparam logic [31:0]       FD_M1    = 32'(FIRST_DELAY - 1);
  localparam logic [31:0]       SD_M1    = 32'(STAGE_DELAY - 1);
  localparam logic [SW-1:0]     LAST     = SW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ALL_ON = {CHANNELS{1'b1}};

  typedef enum logic [1:0] {
    S_WAIT_LOCK,
    S_DELAY,
    S_RELEASE,
    S_DONE
  } state_t;

  // Two-flop synchroniser; lk_reg is the only form of lock the FSM sees.
  logic meta_reg;
  logic lk_reg;

  state_t                state_reg,     state_next;
  logic [SW-1:0]         stage_reg,     stage_next;
  logic [31:0]           timer_reg,     timer_next;
  logic [31:0]           filter_reg,    filter_next;
  logic [CHANNELS-1:0]   reset_out_reg, reset_out_next;
  logic                  done_reg,      done_next;
  logic [15:0]           loss_count_reg, loss_count_next;

  logic abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      lk_reg   <= 1'b0;
    end else begin
      meta_reg <= locked_in;
      lk_reg   <= meta_reg;
    end
  end

  // Abort only applies once sequencing has begun; in WAIT_LOCK a low lock
  // simply clears the filter and a restart has nothing to undo.
  assign abort = (state_reg != S_WAIT_LOCK) && (!lk_reg || restart);

  always_comb begin
    state_next      = state_reg;
    stage_next      = stage_reg;
    timer_next      = timer_reg;
    filter_next     = filter_reg;
    reset_out_next  = reset_out_reg;
    done_next       = done_reg;
    loss_count_next = loss_count_reg;

    if (abort) begin
      state_next     = S_WAIT_LOCK;
      stage_next     = '0;
      timer_next     = '0;
      filter_next    = '0;
      reset_out_next = ALL_ON;
      done_next      = 1'b0;
      // A simultaneous restart and lock loss counts as one lock-loss abort.
      if (!lk_reg && (loss_count_reg != 16'hFFFF)) begin
        loss_count_next = loss_count_reg + 16'd1;
      end
    end else begin
      case (state_reg)
        S_WAIT_LOCK: begin
          if (restart || !lk_reg) begin
            filter_next = '0;
          end else if (filter_reg == LF_M1) begin
            // LOCK_FILTER-th consecutive edge with lock high.
            filter_next = '0;
            timer_next  = FD_M1;
            state_next  = S_DELAY;
          end else begin
            filter_next = filter_reg + 32'd1;
          end
        end

        S_DELAY: begin
          if (timer_reg == 32'd0) begin
            reset_out_next[0] = 1'b0;
            stage_next        = SW'(1);
            if (CHANNELS == 1) begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end else begin
              timer_next = SD_M1;
              state_next = S_RELEASE;
            end
          end else begin
            timer_next = timer_reg - 32'd1;
          end
        end

        S_RELEASE: begin
          if (timer_reg == 32'd0) begin
            for (int k = 0; k < CHANNELS; k++) begin
              if (stage_reg == SW'(k)) begin
                reset_out_next[k] = 1'b0;
              end
            end
            if (stage_reg == LAST) begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end else begin
              stage_next = stage_reg + 1'b1;
              timer_next = SD_M1;
            end
          end else begin
            timer_next = timer_reg - 32'd1;
          end
        end

        S_DONE: begin
          reset_out_next = '0;
          done_next      = 1'b1;
        end

        default: begin
          state_next = S_WAIT_LOCK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_WAIT_LOCK;
      stage_reg      <= '0;
      timer_reg      <= '0;
      filter_reg     <= '0;
      reset_out_reg  <= ALL_ON;
      done_reg       <= 1'b0;
      loss_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      stage_reg      <= stage_next;
      timer_reg      <= timer_next;
      filter_reg     <= filter_next;
      reset_out_reg  <= reset_out_next;
      done_reg       <= done_next;
      loss_count_reg <= loss_count_next;
    end
  end

  assign reset_out  = reset_out_reg;
  assign done       = done_reg;
  assign loss_count = loss_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-channel instance (LOCK_FILTER=4,
// FIRST_DELAY=10, STAGE_DELAY=5) and a 1-channel minimum-delay instance.
// Edge numbering: j=0 is the first rising edge after locked_in is raised;
// the synchroniser makes E(n) (n-th edge with lk high) equal to edge j=n+1.
module tb_reset_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, locked_in, restart;
  logic [2:0]  reset_out;
  logic        done;
  logic [15:0] loss_count;

  logic        min_reset, min_locked, min_restart;
  logic [0:0]  min_reset_out;
  logic        min_done;
  logic [15:0] min_loss;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .CHANNELS(3), .LOCK_FILTER(4), .FIRST_DELAY(10), .STAGE_DELAY(5)
  ) u_dut (
    .clk(clk), .reset(reset), .locked_in(locked_in), .restart(restart),
    .reset_out(reset_out), .done(done), .loss_count(loss_count)
  );

  reset_sequencer #(
    .CHANNELS(1), .LOCK_FILTER(1), .FIRST_DELAY(1), .STAGE_DELAY(1)
  ) u_min (
    .clk(clk), .reset(min_reset), .locked_in(min_locked), .restart(min_restart),
    .reset_out(min_reset_out), .done(min_done), .loss_count(min_loss)
  );

  // Expected reset_out after lk edge n of a clean run (n<1 means not started).
  function automatic logic [2:0] exp_ro(int n);
    if (n >= 24)      return 3'b000;
    else if (n >= 19) return 3'b100;
    else if (n >= 14) return 3'b110;
    else              return 3'b111;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; locked_in = 1'b0; restart = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; locked_in = 1'b0; restart = 1'b0;
    tick(2);
    checks++; if (reset_out !== 3'b111) begin errors++; $display("FAIL reset_ro: got %b want 111", reset_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (loss_count !== 16'd0) begin errors++; $display("FAIL reset_loss: got %0d want 0", loss_count); end
    reset = 1'b0;
    $display("test_reset: reset_out=%b done=%b loss=%0d", reset_out, done, loss_count);
  endtask

  task automatic test_power_up();
    locked_in = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      checks++; if (reset_out !== exp_ro(j - 1)) begin errors++; $display("FAIL pu_ro edge %0d: got %b want %b", j, reset_out, exp_ro(j - 1)); end
      checks++; if (done !== (j - 1 >= 24)) begin errors++; $display("FAIL pu_done edge %0d: got %b want %b", j, done, (j - 1 >= 24)); end
      checks++; if (loss_count !== 16'd0) begin errors++; $display("FAIL pu_loss edge %0d: got %0d want 0", j, loss_count); end
    end
    $display("test_power_up: reset_out=%b done=%b loss=%0d", reset_out, done, loss_count);
  endtask

  task automatic test_lock_filter();
    logic [2:0] want;
    do_reset();
    for (int j = 0; j < 21; j++) begin
      locked_in = (j == 3) ? 1'b0 : 1'b1;
      tick(1);
      want = (j >= 19) ? 3'b110 : 3'b111;
      checks++; if (reset_out !== want) begin errors++; $display("FAIL filt_ro edge %0d: got %b want %b", j, reset_out, want); end
    end
    $display("test_lock_filter: reset_out=%b", reset_out);
  endtask

  task automatic test_lock_loss();
    do_reset();
    for (int j = 0; j < 21; j++) begin
      locked_in = (j >= 19) ? 1'b0 : 1'b1;
      tick(1);
      checks++; if (reset_out !== exp_ro(j - 1)) begin errors++; $display("FAIL loss_pre_ro edge %0d: got %b want %b", j, reset_out, exp_ro(j - 1)); end
    end
    tick(1);
    checks++; if (reset_out !== 3'b111) begin errors++; $display("FAIL loss_abort_ro: got %b want 111", reset_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL loss_abort_done: got %b want 0", done); end
    checks++; if (loss_count !== 16'd1) begin errors++; $display("FAIL loss_abort_cnt: got %0d want 1", loss_count); end
    locked_in = 1'b1;
    for (int j = 0; j < 26; j++) begin
      tick(1);
      checks++; if (reset_out !== exp_ro(j - 1)) begin errors++; $display("FAIL relock_ro edge %0d: got %b want %b", j, reset_out, exp_ro(j - 1)); end
      checks++; if (done !== (j - 1 >= 24)) begin errors++; $display("FAIL relock_done edge %0d: got %b want %b", j, done, (j - 1 >= 24)); end
      checks++; if (loss_count !== 16'd1) begin errors++; $display("FAIL relock_loss edge %0d: got %0d want 1", j, loss_count); end
    end
    $display("test_lock_loss: reset_out=%b done=%b loss=%0d", reset_out, done, loss_count);
  endtask

  task automatic test_restart_done();
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if (reset_out !== 3'b111) begin errors++; $display("FAIL rst_ro: got %b want 111", reset_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (loss_count !== 16'd1) begin errors++; $display("FAIL rst_loss: got %0d want 1", loss_count); end
    for (int m = 1; m <= 25; m++) begin
      tick(1);
      checks++; if (reset_out !== exp_ro(m)) begin errors++; $display("FAIL rst_seq_ro edge %0d: got %b want %b", m, reset_out, exp_ro(m)); end
      checks++; if (done !== (m >= 24)) begin errors++; $display("FAIL rst_seq_done edge %0d: got %b want %b", m, done, (m >= 24)); end
    end
    $display("test_restart_done: reset_out=%b done=%b loss=%0d", reset_out, done, loss_count);
  endtask

  task automatic test_simultaneous();
    locked_in = 1'b0;
    tick(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL simul_pre_done: got %b want 1", done); end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    checks++; if (reset_out !== 3'b111) begin errors++; $display("FAIL simul_ro: got %b want 111", reset_out); end
    checks++; if (loss_count !== 16'd2) begin errors++; $display("FAIL simul_loss: got %0d want 2", loss_count); end
    $display("test_simultaneous: reset_out=%b loss=%0d", reset_out, loss_count);
  endtask

  task automatic test_reset_mid();
    locked_in = 1'b1;
    tick(20);
    checks++; if (reset_out !== 3'b110) begin errors++; $display("FAIL mid_pre_ro: got %b want 110", reset_out); end
    reset = 1'b1;
    tick(1);
    checks++; if (reset_out !== 3'b111) begin errors++; $display("FAIL mid_ro: got %b want 111", reset_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done); end
    checks++; if (loss_count !== 16'd0) begin errors++; $display("FAIL mid_loss: got %0d want 0", loss_count); end
    reset = 1'b0;
    $display("test_reset_mid: reset_out=%b done=%b loss=%0d", reset_out, done, loss_count);
  endtask

  task automatic test_single_min();
    min_reset = 1'b1; min_locked = 1'b0; min_restart = 1'b0;
    tick(2);
    min_reset = 1'b0;
    min_locked = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick(1);
      checks++; if (min_reset_out !== ((j - 1 >= 2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL min_ro edge %0d: got %b want %b", j, min_reset_out, (j - 1 < 2)); end
      checks++; if (min_done !== (j - 1 >= 2)) begin errors++; $display("FAIL min_done edge %0d: got %b want %b", j, min_done, (j - 1 >= 2)); end
    end
    $display("test_single_min: reset_out=%b done=%b", min_reset_out, min_done);
  endtask

  task automatic test_saturation();
    logic [15:0] exp_loss;
    exp_loss = 16'd0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        // Jump near the top instead of spending 65k+ abort cycles.
        force u_min.loss_count_reg = 16'hFFFD;
        tick(1);
        release u_min.loss_count_reg;
        exp_loss = 16'hFFFD;
      end
      min_locked = 1'b0;
      tick(3);
      exp_loss = (exp_loss == 16'hFFFF) ? 16'hFFFF : exp_loss + 16'd1;
      checks++; if (min_loss !== exp_loss) begin errors++; $display("FAIL sat_loss iter %0d: got %h want %h", i, min_loss, exp_loss); end
      $display("test_saturation: iter %0d loss=%h", i, min_loss);
      min_locked = 1'b1;
      tick(3);
    end
    min_reset = 1'b1;
    tick(1);
    min_reset = 1'b0;
    checks++; if (min_loss !== 16'd0) begin errors++; $display("FAIL sat_reset_loss: got %h want 0", min_loss); end
    checks++; if (min_reset_out !== 1'b1) begin errors++; $display("FAIL sat_reset_ro: got %b want 1", min_reset_out); end
  endtask

  initial begin
    reset = 1'b1; locked_in = 1'b0; restart = 1'b0;
    min_reset = 1'b1; min_locked = 1'b0; min_restart = 1'b0;
    test_reset();
    test_power_up();
    test_lock_filter();
    test_lock_loss();
    test_restart_done();
    test_simultaneous();
    test_reset_mid();
    test_single_min();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
